// File: rtl/ccg_bist_harness.sv
// BIST harness for combinational CUTs: LFSR or counter stimulus,
// MISR compaction of the CUT response, and a golden-signature compare.
// Ports: clk, rst_n, start, mode, seed, num_patterns, abort, golden,
//        cut_in, cut_out, busy, done, pass, signature, pat_cnt.
module ccg_bist_harness #(
  parameter int N_IN   = 14,
  parameter int N_OUT  = 17,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 1,
  parameter logic [N_IN-1:0]  LFSR_TAPS = 14'b11_0000_0000_0010,
  parameter logic [N_OUT-1:0] MISR_TAPS = 17'h12000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [N_IN-1:0]  seed,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic             abort,
  input  logic [N_OUT-1:0] golden,
  output logic [N_IN-1:0]  cut_in,
  input  logic [N_OUT-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] signature,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CAPTURE,
    FIN
  } state_t;

  state_t           state;
  logic             mode_q;
  logic [CNT_W-1:0] num_q;
  logic [SW-1:0]    settle_cnt;

  logic [N_IN-1:0]  pat_next;
  logic [N_OUT-1:0] misr_next;
  logic [CNT_W-1:0] cnt_inc;

  assign pat_next = mode_q ? cut_in + 1'b1
                  : {cut_in[N_IN-2:0], ^(cut_in & LFSR_TAPS)};
  assign misr_next =
    {signature[N_OUT-2:0], ^(signature & MISR_TAPS)} ^ cut_out;
  assign cnt_inc = pat_cnt + 1'b1;

  // golden is live, so pass follows it while done is held
  assign pass = done && (signature == golden);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      num_q      <= '0;
      settle_cnt <= '0;
      cut_in     <= '0;
      signature  <= '0;
      pat_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, FIN: begin
          if (start) begin
            mode_q     <= mode;
            num_q      <= num_patterns;
            settle_cnt <= '0;
            signature  <= '0;
            pat_cnt    <= '0;
            // all-zero seed would lock the LFSR
            cut_in <= (!mode && seed == '0) ? N_IN'(1) : seed;
            if (num_patterns == '0) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= APPLY;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        APPLY: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (settle_cnt == SET_LAST) begin
            state      <= CAPTURE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            signature <= misr_next;
            pat_cnt   <= cnt_inc;
            cut_in    <= pat_next;
            if (cnt_inc == num_q) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= APPLY;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccg_bist_harness.sv
// Directed bench for ccg_bist_harness with a pattern scoreboard
// and an independent LFSR/MISR reference model.
module tb_ccg_bist_harness;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        abort = 1'b0;
  logic [13:0] seed = '0;
  logic [15:0] num_patterns = '0;
  logic [16:0] golden = '0;
  logic [13:0] cut_in;
  logic [16:0] cut_out;
  logic [16:0] signature;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] pat_cnt;

  int total = 0;
  int bad = 0;
  logic [13:0] expq[$];

  assign cut_out = {3'b000, cut_in};

  always #5 clk = ~clk;

  ccg_bist_harness dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mode(mode),
    .seed(seed),
    .num_patterns(num_patterns),
    .abort(abort),
    .golden(golden),
    .cut_in(cut_in),
    .cut_out(cut_out),
    .busy(busy),
    .done(done),
    .pass(pass),
    .signature(signature),
    .pat_cnt(pat_cnt)
  );

  function automatic logic [13:0] lfsr_step(input logic [13:0] x);
    return {x[12:0], x[13] ^ x[12] ^ x[1]};
  endfunction

  function automatic logic [16:0] misr_step(input logic [16:0] s,
                                            input logic [16:0] d);
    return {s[15:0], s[16] ^ s[13]} ^ d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input logic m, input logic [13:0] s,
                        input logic [15:0] n);
    logic [13:0] p;
    logic [13:0] e;
    logic [16:0] sig;
    p = (!m && s == 14'd0) ? 14'd1 : s;
    sig = '0;
    for (int i = 0; i < int'(n); i++) begin
      expq.push_back(p);
      sig = misr_step(sig, {3'b000, p});
      p = m ? p + 14'd1 : lfsr_step(p);
    end
    @(negedge clk);
    mode = m;
    seed = s;
    num_patterns = n;
    golden = sig;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, n != 0);
    chk("done_after_start", done, n == 0);
    for (int i = 0; i < int'(n); i++) begin
      e = expq.pop_front();
      chk("pattern", cut_in, e);
      @(posedge clk);
      #1;
      chk("done_early", done, 0);
      chk("busy_run", busy, 1);
      @(posedge clk);
      #1;
    end
    chk("done_end", done, 1);
    chk("busy_end", busy, 0);
    chk("signature", signature, sig);
    chk("pat_cnt_end", pat_cnt, n);
    chk("pass_good", pass, 1);
    chk("next_pattern", cut_in, p);
    golden = sig ^ 17'd1;
    #1 chk("pass_bad_golden", pass, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_cut_in", cut_in, 0);
    chk("rst_sig", signature, 0);
    chk("rst_cnt", pat_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_run(1'b1, 14'h0000, 16'd4);
    chk("t2_sig_const", signature, 17'h00003);
    do_run(1'b0, 14'h0000, 16'd20);
    do_run(1'b1, 14'h3FFE, 16'd3);
    do_run(1'b0, 14'h1A5C, 16'd0);
    do_run(1'b0, 14'h2B71, 16'd7);

    // start while busy is ignored, then abort after two captures
    @(negedge clk);
    mode = 1'b1;
    seed = 14'h0010;
    num_patterns = 16'd10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ab_first", cut_in, 14'h0010);
    chk("ab_done_clr", done, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("ab_second", cut_in, 14'h0011);
    seed = 14'h0200;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ign_cut_in", cut_in, 14'h0011);
    chk("ign_busy", busy, 1);
    @(posedge clk);
    #1;
    chk("ab_cnt_pre", pat_cnt, 2);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_cnt", pat_cnt, 2);
    chk("ab_cut_hold", cut_in, 14'h0012);
    repeat (3) @(posedge clk);
    #1;
    chk("ab_idle_busy", busy, 0);

    // restart from IDLE, then from DONE; abort in DONE is inert
    do_run(1'b1, 14'h0100, 16'd5);
    do_run(1'b0, 14'h0001, 16'd6);
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_in_done", done, 1);

    // asynchronous reset mid-run
    @(negedge clk);
    mode = 1'b0;
    seed = 14'h0123;
    num_patterns = 16'd10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_cnt", pat_cnt, 1);
    chk("mid_sig", signature, 17'h00123);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cut", cut_in, 0);
    chk("mid_rst_sig", signature, 0);
    chk("mid_rst_cnt", pat_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cut", cut_in, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
